hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised RAW-hazard tracker that succeeds the stage-compare hazard check in the pipeline control logic. It keeps a per-register up/down counter of in-flight writes and gates ID->EX issue until every source operand is free. It supports squash of killed in-flight instructions, a drain mode for CSR/fence-type serialisation, and a saturating stall-cycle counter. It sits beside control and feeds its issue_ready_o into the ID-stage stall/valid logic.

Parameters:
NUM_REGS, 32, architectural registers tracked; register 0 never tracked.
REG_ADDR_W, $clog2(NUM_REGS), register index width.
NUM_SRC, 2, source operands checked per issuing instruction.
NUM_KILL, 2, squash ports (one per squashable stage past ID, e.g. EX and MEM).
CNT_W, 2, per-register counter width; max in-flight writes per register = 2**CNT_W-1.
PERF_W, 32, stall counter width.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
issue_valid_i  in  1  valid instruction in ID requesting issue
issue_rs_i  in  NUM_SRC*REG_ADDR_W  source register indices; slot k at bits [k*REG_ADDR_W +: REG_ADDR_W]
issue_rs_used_i  in  NUM_SRC  slot k is a real operand
issue_rd_i  in  REG_ADDR_W  destination register
issue_rd_we_i  in  1  instruction writes rd
issue_ready_o  out  1  issue permitted this cycle (combinational)
retire_valid_i  in  1  WB register write completes this cycle
retire_rd_i  in  REG_ADDR_W  retiring destination
kill_valid_i  in  NUM_KILL  squashed in-flight instruction with a pending write
kill_rd_i  in  NUM_KILL*REG_ADDR_W  its destination
drain_i  in  1  serialisation request: block issue until nothing is in flight
drained_o  out  1  all counters zero
busy_o  out  NUM_REGS  bit r = cnt[r] != 0; bit 0 always 0
error_o  out  1  sticky: underflow occurred
stall_count_o  out  PERF_W  cycles with issue_valid_i && !issue_ready_o

Behaviour:
- Reset (synchronous; beats every same-cycle event): all cnt = 0, busy_o = 0, error_o = 0, stall_count_o = 0. drained_o = 1 after reset.
- Issue fire = issue_valid_i && issue_ready_o.
- On fire with issue_rd_we_i && rd != 0: cnt[rd] increments.
- issue_ready_o = 1 when all three hold:
  - no slot k with issue_rs_used_i[k] and cnt[rs_k] != 0 (rs = 0 is always free);
  - not (issue_rd_we_i && rd != 0 && cnt[rd] == max), which guards overflow;
  - not (drain_i && !drained_o).
- Decrements: retire_valid_i gives one decrement on retire_rd_i; each kill_valid_i[j] gives one decrement on kill_rd_i[j]. Decrements to the same register in one cycle sum. rd = 0 is ignored.
- Net update per register: cnt_next = cnt + inc - dec, all in the same cycle. Simultaneous issue and retire on one register leaves the count unchanged.
- Underflow (dec > cnt + inc): cnt clamps to 0 and error_o sets; it clears only on reset.
- Readiness is computed from registered counts only. A retire in cycle N releases dependants in cycle N+1 (WB-write then ID-read ordering), so worst-case issue latency after retire is 1 cycle.
- drained_o = all cnt == 0 (registered state). Drain adds no extra latency: issue proceeds in the first cycle drained_o = 1.
- stall_count_o increments on each cycle with issue_valid_i && !issue_ready_o and saturates at all-ones.
- busy_o and drained_o are derived from registered counts, so they are glitch-free.

Decomposition:
- Shared package (definitions): `scoreboard_cnt_t` typedef (logic [CNT_W-1:0]) and a REG_ZERO index constant.
- One sub-module, scoreboard_counter: a single saturating up/down counter.
  - Inputs: inc (1 bit) and dec (0..NUM_KILL+1).
  - Outputs: count, nonzero, full, underflow.
  - Instantiated NUM_REGS-1 times in a generate loop.
- Top level holds the index decode, ready reduction, drain logic and perf counter.

Test Plan:
- Reset, then issue x5 write; next cycle issue reader of rs1 = x5 -> issue_ready_o = 0, busy_o[5] = 1. Retire x5 in cycle N -> ready = 1 in cycle N+1.
- Issue three writes to x7 with CNT_W = 2 -> cnt = 3; a fourth write to x7 -> ready = 0 until one retire, then it fires and cnt returns to 3.
- Issue writes x3 and x4; assert kill_valid_i = 2'b11 with kill_rd = {x4, x3} -> both busy bits clear next cycle, drained_o = 1, error_o = 0.
- Same cycle: issue write x9 and retire x9 with cnt[9] = 1 -> cnt[9] stays 1. Retire x9 with cnt[9] = 0 -> error_o = 1 and cnt stays 0.
- drain_i = 1 with x2 in flight and an independent instruction (rs = x10) -> blocked, stall_count_o increments per cycle. Retire x2 -> issue fires next cycle.
- Writes/reads on x0 never stall and never set busy_o[0]. Assert reset_i mid-stream with counts nonzero -> next cycle all counts = 0, stall_count_o = 0, ready = 1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the RAW-hazard scoreboard.
// The count type and the untracked register index live here.
package hazard_scoreboard_pkg;

    localparam int SB_CNT_W = 2;
    localparam int REG_ZERO = 0;

    typedef logic [SB_CNT_W-1:0] scoreboard_cnt_t;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// One in-flight write counter: +inc, -dec in the same cycle.
// The result clamps to 0 on underflow and to all-ones on overflow.
module scoreboard_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int DEC_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             full,
    output logic             underflow
);

    // Wide enough that count + inc and the difference never wrap.
    localparam int SW = CNT_W + DEC_W + 1;

    logic [SW-1:0]    sum, dec_w, diff;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        sum        = SW'(count) + SW'(inc);
        dec_w      = SW'(dec);
        diff       = sum - dec_w;
        underflow  = dec_w > sum;
        count_next = '0;
        if (!underflow)
            count_next = (diff > SW'({CNT_W{1'b1}})) ? '1 : diff[CNT_W-1:0];
    end

    assign nonzero = |count;
    assign full    = &count;

    always_ff @(posedge clk_i) begin
        if (reset_i) count <= '0;
        else         count <= count_next;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard scoreboard: per-register in-flight write counts gate ID->EX issue,
// with squash ports, drain-based serialisation and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = $clog2(NUM_REGS),
    parameter int NUM_SRC    = 2,
    parameter int NUM_KILL   = 2,
    parameter int CNT_W      = SB_CNT_W,
    parameter int PERF_W     = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           issue_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  issue_rs_i,
    input  logic [NUM_SRC-1:0]             issue_rs_used_i,
    input  logic [REG_ADDR_W-1:0]          issue_rd_i,
    input  logic                           issue_rd_we_i,
    output logic                           issue_ready_o,
    input  logic                           retire_valid_i,
    input  logic [REG_ADDR_W-1:0]          retire_rd_i,
    input  logic [NUM_KILL-1:0]            kill_valid_i,
    input  logic [NUM_KILL*REG_ADDR_W-1:0] kill_rd_i,
    input  logic                           drain_i,
    output logic                           drained_o,
    output logic [NUM_REGS-1:0]            busy_o,
    output logic                           error_o,
    output logic [PERF_W-1:0]              stall_count_o
);

    // Up to one retire plus one decrement per kill port per cycle.
    localparam int DEC_W = $clog2(NUM_KILL + 2);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            nonzero, full;
    logic [NUM_REGS-1:1]            inc, underflow;
    logic [NUM_REGS-1:1][DEC_W-1:0] dec;
    logic                           rd_tracked, src_hazard, fire;

    assign cnt[REG_ZERO]     = '0;
    assign nonzero[REG_ZERO] = 1'b0;
    assign full[REG_ZERO]    = 1'b0;

    assign rd_tracked = issue_rd_we_i && (issue_rd_i != REG_ADDR_W'(REG_ZERO));

    always_comb begin
        src_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++)
            if (issue_rs_used_i[k] && nonzero[issue_rs_i[k*REG_ADDR_W +: REG_ADDR_W]])
                src_hazard = 1'b1;
    end

    // Readiness looks only at registered counts: a retire frees dependants next cycle.
    assign issue_ready_o = !src_hazard
                        && !(rd_tracked && full[issue_rd_i])
                        && !(drain_i && !drained_o);
    assign fire = issue_valid_i && issue_ready_o;

    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r] = fire && rd_tracked && (issue_rd_i == REG_ADDR_W'(r));
            dec[r] = '0;
            if (retire_valid_i && retire_rd_i == REG_ADDR_W'(r))
                dec[r] = dec[r] + DEC_W'(1);
            for (int j = 0; j < NUM_KILL; j++)
                if (kill_valid_i[j] && kill_rd_i[j*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))
                    dec[r] = dec[r] + DEC_W'(1);
        end
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        scoreboard_counter #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .count     (cnt[r]),
            .nonzero   (nonzero[r]),
            .full      (full[r]),
            .underflow (underflow[r])
        );
    end

    assign busy_o    = nonzero;
    assign drained_o = (cnt == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_o       <= 1'b0;
            stall_count_o <= '0;
        end else begin
            if (|underflow)
                error_o <= 1'b1;
            if (issue_valid_i && !issue_ready_o && stall_count_o != '1)
                stall_count_o <= stall_count_o + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: issue/retire, overflow guard, kill,
// same-cycle update, underflow, drain, x0 handling and mid-stream reset.
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          issue_valid_i;
    logic [2*AW-1:0] issue_rs_i;
    logic [1:0]    issue_rs_used_i;
    logic [AW-1:0] issue_rd_i;
    logic          issue_rd_we_i;
    logic          issue_ready_o;
    logic          retire_valid_i;
    logic [AW-1:0] retire_rd_i;
    logic [1:0]    kill_valid_i;
    logic [2*AW-1:0] kill_rd_i;
    logic          drain_i;
    logic          drained_o;
    logic [NR-1:0] busy_o;
    logic          error_o;
    logic [31:0]   stall_count_o;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rs_i      (issue_rs_i),
        .issue_rs_used_i (issue_rs_used_i),
        .issue_rd_i      (issue_rd_i),
        .issue_rd_we_i   (issue_rd_we_i),
        .issue_ready_o   (issue_ready_o),
        .retire_valid_i  (retire_valid_i),
        .retire_rd_i     (retire_rd_i),
        .kill_valid_i    (kill_valid_i),
        .kill_rd_i       (kill_rd_i),
        .drain_i         (drain_i),
        .drained_o       (drained_o),
        .busy_o          (busy_o),
        .error_o         (error_o),
        .stall_count_o   (stall_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid_i   = 1'b0;
        issue_rs_i      = '0;
        issue_rs_used_i = '0;
        issue_rd_i      = '0;
        issue_rd_we_i   = 1'b0;
        retire_valid_i  = 1'b0;
        retire_rd_i     = '0;
        kill_valid_i    = '0;
        kill_rd_i       = '0;
        drain_i         = 1'b0;
    endtask

    task automatic issue(input int rs0, input bit used0, input int rd, input bit we);
        issue_valid_i   = 1'b1;
        issue_rs_i      = {AW'(0), AW'(rs0)};
        issue_rs_used_i = {1'b0, used0};
        issue_rd_i      = AW'(rd);
        issue_rd_we_i   = we;
    endtask

    task automatic retire(input int rd);
        retire_valid_i = 1'b1;
        retire_rd_i    = AW'(rd);
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
        settle();
        chk("rst_busy",    busy_o, 0);
        chk("rst_drained", drained_o, 1);
        chk("rst_error",   error_o, 0);
        chk("rst_stall",   stall_count_o, 0);
        chk("rst_ready",   issue_ready_o, 1);

        // Write x5, then a reader of x5 stalls until the cycle after its retire.
        issue(0, 0, 5, 1); settle();
        chk("w5_ready", issue_ready_o, 1);
        tick(); idle();
        issue(5, 1, 6, 0); settle();
        chk("raw5_ready", issue_ready_o, 0);
        chk("raw5_busy",  busy_o[5], 1);
        retire(5); settle();
        chk("raw5_ready_retire_cycle", issue_ready_o, 0);
        tick(); retire_valid_i = 1'b0; settle();
        chk("raw5_ready_after", issue_ready_o, 1);
        chk("raw5_busy_after",  busy_o[5], 0);
        tick(); idle(); settle();
        chk("stall_after_raw", stall_count_o, 1);

        // Three writes to x7 fill the counter; a fourth waits for a retire.
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 7, 1); settle();
            chk("w7_ready", issue_ready_o, 1);
            tick();
        end
        settle();
        chk("w7_ready_full", issue_ready_o, 0);
        tick();
        retire(7); settle();
        chk("w7_ready_retire_cycle", issue_ready_o, 0);
        tick(); retire_valid_i = 1'b0; settle();
        chk("w7_ready_after_retire", issue_ready_o, 1);
        tick(); settle();
        chk("w7_full_again", issue_ready_o, 0);
        idle();
        chk("stall_after_w7", stall_count_o, 3);
        retire(7); tick(); tick(); settle();
        chk("w7_one_left", busy_o[7], 1);
        tick(); idle(); settle();
        chk("w7_drained", drained_o, 1);

        // Two kills in one cycle clear x3 and x4.
        issue(0, 0, 3, 1); tick();
        issue(0, 0, 4, 1); tick(); idle(); settle();
        chk("kill_busy_before", busy_o[4:3], 2'b11);
        kill_valid_i = 2'b11;
        kill_rd_i    = {AW'(4), AW'(3)};
        tick(); idle(); settle();
        chk("kill_busy_after", busy_o[4:3], 2'b00);
        chk("kill_drained",    drained_o, 1);
        chk("kill_error",      error_o, 0);

        // x0 is never tracked: writes, reads and retires of x0 have no effect.
        issue(0, 1, 0, 1); settle();
        chk("x0_ready", issue_ready_o, 1);
        tick(); tick(); settle();
        chk("x0_ready_repeat", issue_ready_o, 1);
        idle(); retire(0); tick(); idle(); settle();
        chk("x0_busy",    busy_o[0], 0);
        chk("x0_drained", drained_o, 1);
        chk("x0_error",   error_o, 0);

        // Same-cycle issue and retire on x9 leaves the count at 1.
        issue(0, 0, 9, 1); tick();
        retire(9); tick(); idle(); settle();
        chk("x9_same_cycle_busy", busy_o[9], 1);
        retire(9); tick(); idle(); settle();
        chk("x9_retired_busy",  busy_o[9], 0);
        chk("x9_retired_error", error_o, 0);
        retire(9); tick(); idle(); settle();
        chk("x9_underflow_error", error_o, 1);
        chk("x9_underflow_busy",  busy_o[9], 0);
        chk("x9_underflow_drain", drained_o, 1);

        // Drain blocks an independent instruction until x2 retires.
        issue(0, 0, 2, 1); tick(); idle();
        drain_i = 1'b1;
        issue(10, 1, 11, 1); settle();
        chk("drain_blocked", issue_ready_o, 0);
        tick(); settle();
        chk("drain_stall_step", stall_count_o, 4);
        tick();
        retire(2); settle();
        chk("drain_blocked_retire_cycle", issue_ready_o, 0);
        tick(); retire_valid_i = 1'b0; settle();
        chk("drain_released", issue_ready_o, 1);
        chk("drain_drained",  drained_o, 1);
        tick(); idle(); settle();
        chk("drain_fired_busy11", busy_o[11], 1);
        chk("drain_stall_total",  stall_count_o, 6);

        // Mid-stream reset with counts nonzero and a stalled reader.
        issue(0, 0, 12, 1); tick();
        issue(12, 1, 13, 1); tick(); settle();
        chk("pre_reset_busy", busy_o[13:11], 3'b011);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0; settle();
        chk("mid_reset_busy",    busy_o, 0);
        chk("mid_reset_stall",   stall_count_o, 0);
        chk("mid_reset_error",   error_o, 0);
        chk("mid_reset_ready",   issue_ready_o, 1);
        chk("mid_reset_drained", drained_o, 1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
